// File: rtl/seq_divider.sv
// seq_divider
//   Iterative restoring divider. Takes a double-width unsigned dividend and a
//   single-width unsigned divisor. Produces a double-width quotient and a
//   single-width remainder, one quotient bit per clock, MSB first.
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        asynchronous reset, active-high (asserted = 1)
//   in_valid     dividend_in/divisor_in valid
//   in_ready     block can accept an operand pair (IDLE only)
//   dividend_in  unsigned dividend, DOUBLE_DATA_WIDTH bits
//   divisor_in   unsigned divisor, DATA_WIDTH bits
//   out_valid    result valid (DONE only)
//   out_ready    consumer takes the result
//   quot_out     unsigned quotient, DOUBLE_DATA_WIDTH bits
//   rem_out      unsigned remainder, DATA_WIDTH bits
//   div_by_zero  result came from a zero divisor

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module seq_divider #(
  parameter int DATA_WIDTH        = `DATA_WIDTH,
  parameter int DOUBLE_DATA_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DOUBLE_DATA_WIDTH-1:0] dividend_in,
  input  logic [DATA_WIDTH-1:0]        divisor_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DOUBLE_DATA_WIDTH-1:0] quot_out,
  output logic [DATA_WIDTH-1:0]        rem_out,
  output logic                         div_by_zero
);

  localparam int W   = DATA_WIDTH;
  localparam int DW  = DOUBLE_DATA_WIDTH;
  localparam int CW  = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DW-1:0] r_dividend;   // shifts left, MSB feeds the trial subtract
  logic [W-1:0]  r_divisor;
  logic [W-1:0]  r_prem;       // partial remainder
  logic [DW-2:0] r_quot;       // quotient bits gathered so far
  logic [CW-1:0] r_count;
  logic          r_zero;       // operation has a zero divisor

  logic [DW-1:0] r_quot_out;
  logic [W-1:0]  r_rem_out;
  logic          r_dbz;

  logic          w_accept;
  logic          w_last;
  logic [W:0]    w_trial;
  logic          w_ge;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_prem_next;
  logic [DW-1:0] w_quot_next;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_count == LAST);

  // One restoring step. When trial >= divisor the true difference is below
  // 2^W, so the low W bits of the narrow subtract are exact.
  assign w_trial     = {r_prem, r_dividend[DW-1]};
  assign w_ge        = (w_trial >= {1'b0, r_divisor});
  assign w_diff      = w_trial[W-1:0] - r_divisor;
  assign w_prem_next = w_ge ? w_diff : w_trial[W-1:0];
  assign w_quot_next = {r_quot, w_ge};

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = BUSY;
      BUSY:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // in_ready is held low for the whole time reset is asserted.
  assign in_ready  = (r_state == IDLE) && !rst_n;
  assign out_valid = (r_state == DONE);

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_prem     <= '0;
      r_quot     <= '0;
      r_count    <= '0;
      r_zero     <= 1'b0;
      r_quot_out <= '0;
      r_rem_out  <= '0;
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_dividend <= dividend_in;
      r_divisor  <= divisor_in;
      r_prem     <= '0;
      r_quot     <= '0;
      r_zero     <= (divisor_in == '0);
      // A zero divisor spends one settle cycle with no arithmetic, which
      // places its result one edge after the accept.
      r_count    <= (divisor_in == '0) ? LAST : '0;
    end else if (r_state == BUSY) begin
      if (!r_zero) begin
        r_dividend <= {r_dividend[DW-2:0], 1'b0};
        r_prem     <= w_prem_next;
        r_quot     <= w_quot_next[DW-2:0];
      end
      r_count <= r_count + 1'b1;
      // Results become visible only on entry to DONE.
      if (w_last) begin
        if (r_zero) begin
          r_quot_out <= '1;
          r_rem_out  <= r_dividend[W-1:0];
          r_dbz      <= 1'b1;
        end else begin
          r_quot_out <= w_quot_next;
          r_rem_out  <= w_prem_next;
          r_dbz      <= 1'b0;
        end
      end
    end
  end

  assign quot_out    = r_quot_out;
  assign rem_out     = r_rem_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at DATA_WIDTH=8, with a random back-to-back
// section checked against integer division.

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend_in;
  logic [7:0]  divisor_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot_out;
  logic [7:0]  rem_out;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_divider #(.DATA_WIDTH(8), .DOUBLE_DATA_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot_out    (quot_out),
    .rem_out     (rem_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic issue(input logic [15:0] dd, input logic [7:0] dv);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    dividend_in = dd;
    divisor_in  = dv;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    dividend_in = 16'($urandom);
    divisor_in  = 8'($urandom);
  endtask

  // lat = k means out_valid was first seen after edge E0+k.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_rise", 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] q,
                              input logic [7:0] r, input logic z);
    chk({tag, "_quot"}, 32'(quot_out), 32'(q));
    chk({tag, "_rem"},  32'(rem_out),  32'(r));
    chk({tag, "_dbz"},  32'(div_by_zero), 32'(z));
  endtask

  // out_ready must already be 1; one edge releases the result.
  task automatic release_chk(input string tag);
    @(negedge clk);
    chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_ready"}, 32'(in_ready),  32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                        input logic [15:0] q, input logic [7:0] r, input logic z,
                        input int exp_lat);
    int lat;
    issue(dd, dv);
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_result(tag, q, r, z);
    $display("[TB] %s: %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d",
             tag, dd, dv, quot_out, rem_out, div_by_zero, lat);
  endtask

  initial begin
    logic [15:0] e_dd [3];
    logic [7:0]  e_dv [3];
    logic [15:0] e_q  [3];
    logic [7:0]  e_r  [3];
    int          lat;

    e_dd[0] = 16'hFFFF; e_dv[0] = 8'h01; e_q[0] = 16'hFFFF; e_r[0] = 8'd0;
    e_dd[1] = 16'd5;    e_dv[1] = 8'd9;  e_q[1] = 16'd0;    e_r[1] = 8'd5;
    e_dd[2] = 16'hFFFF; e_dv[2] = 8'hFF; e_q[2] = 16'h0101; e_r[2] = 8'd0;

    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend_in = '0;
    divisor_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),    32'd0);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    check_result("rst", 16'd0, 8'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic
    out_ready = 1'b1;
    run_op("basic", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
    release_chk("basic");

    // Edge values
    for (int i = 0; i < 3; i++) begin
      run_op("edge", e_dd[i], e_dv[i], e_q[i], e_r[i], 1'b0, 16);
      release_chk("edge");
    end

    // Divide by zero
    run_op("dbz", 16'h04D2, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1);
    release_chk("dbz");

    // Backpressure
    out_ready = 1'b0;
    run_op("bp", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
    for (int i = 0; i < 5; i++) begin
      in_valid    = 1'b1;
      dividend_in = 16'd99;
      divisor_in  = 8'd4;
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
      check_result("bp_hold", 16'd142, 8'd6, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    release_chk("bp");
    @(negedge clk);
    chk("bp_single_release", 32'(out_valid), 32'd0);
    run_op("bp_next", 16'd200, 8'd3, 16'd66, 8'd2, 1'b0, 16);
    release_chk("bp_next");

    // Reset mid-BUSY
    issue(16'd1000, 8'd7);
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    check_result("midrst", 16'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_idle",      32'(in_ready),  32'd1);
    chk("midrst_no_output", 32'(out_valid), 32'd0);
    run_op("after_rst", 16'd200, 8'd3, 16'd66, 8'd2, 1'b0, 16);
    release_chk("after_rst");

    // Randomised back-to-back against integer division
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] dd;
      logic [7:0]  dv;
      logic [15:0] q;
      logic [7:0]  r;
      int          stall;
      dd = 16'($urandom);
      dv = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (dv == 8'd0) begin
        q = 16'hFFFF;
        r = dd[7:0];
      end else begin
        q = dd / 16'(dv);
        r = 8'(dd % 16'(dv));
      end
      out_ready = 1'($urandom_range(0, 1));
      issue(dd, dv);
      wait_done(lat);
      chk("rnd_latency", 32'(lat), (dv == 8'd0) ? 32'd1 : 32'd16);
      check_result("rnd", q, r, (dv == 8'd0));
      if (dv != 8'd0) begin
        chk("rnd_invariant", 32'(quot_out) * 32'(dv) + 32'(rem_out), 32'(dd));
        chk("rnd_rem_lt_div", 32'(rem_out < dv), 32'd1);
      end
      $display("[TB] rnd %0d: %0d / %0d -> q=%0d r=%0d dbz=%0b",
               n, dd, dv, quot_out, rem_out, div_by_zero);
      if (out_ready == 1'b0) begin
        stall = $urandom_range(0, 3);
        repeat (stall) @(negedge clk);
        chk("rnd_stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
      release_chk("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
